// File: rtl/mem_write_buffer_pkg.sv
// ----------------------------------------------------------------------------
// mem_write_buffer_pkg
// Shared definitions for the write-through store buffer:
//   - default address/data widths (common with cache_controller)
//   - drain-state encoding used by the buffer's drain FSM
// ----------------------------------------------------------------------------
package mem_write_buffer_pkg;

    localparam int WB_ADDR_W = 16;
    localparam int WB_DATA_W = 32;

    typedef enum logic {
        WB_IDLE  = 1'b0,
        WB_DRAIN = 1'b1
    } wb_state_e;

endpackage : mem_write_buffer_pkg

// File: rtl/wb_entry_array.sv
// ----------------------------------------------------------------------------
// wb_entry_array
// Storage for the store-buffer entries (valid/addr/data per slot).
// Ports:
//   clk, rst_n              clock, async active-low reset (clears all valids)
//   wr_en/wr_idx/wr_addr/wr_data   write port (new entry or coalesce overwrite)
//   clr_en/clr_idx          invalidate a slot (head pop)
//   head_idx                current head; excluded from coalesce matching
//   coal_addr -> coal_hit/coal_idx   non-head address match for coalescing
//   fwd_addr  -> fwd_hit/fwd_data    forwarding lookup (non-head beats head)
//   rd_idx    -> rd_addr/rd_data     plain read used to load the RAM port
// ----------------------------------------------------------------------------
module wb_entry_array
    import mem_write_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_idx,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_en,
    input  logic [PTR_W-1:0]  clr_idx,
    input  logic [PTR_W-1:0]  head_idx,
    input  logic [ADDR_W-1:0] coal_addr,
    output logic              coal_hit,
    output logic [PTR_W-1:0]  coal_idx,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    input  logic [PTR_W-1:0]  rd_idx,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DEPTH-1:0]  valid_r;
    logic [ADDR_W-1:0] addr_r [DEPTH];
    logic [DATA_W-1:0] data_r [DEPTH];

    logic [DEPTH-1:0]  coal_vec_s;
    logic [DEPTH-1:0]  fwd_vec_s;
    logic [DATA_W-1:0] fwd_nh_data_s;
    logic              fwd_head_hit_s;

    // Per-slot match vectors; the head slot never takes part in either
    // vector because it may already be presented to RAM.
    always_comb begin
        coal_vec_s = {DEPTH{1'b0}};
        fwd_vec_s  = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            coal_vec_s[i] = valid_r[i] && (PTR_W'(i) != head_idx) && (addr_r[i] == coal_addr);
            fwd_vec_s[i]  = valid_r[i] && (PTR_W'(i) != head_idx) && (addr_r[i] == fwd_addr);
        end
    end

    // Encode coalesce index and select non-head forwarding data (at most one
    // non-head slot per address exists, so a plain one-hot mux suffices).
    always_comb begin
        coal_idx      = {PTR_W{1'b0}};
        fwd_nh_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            coal_idx      = coal_vec_s[i] ? PTR_W'(i) : coal_idx;
            fwd_nh_data_s = fwd_vec_s[i] ? data_r[i] : fwd_nh_data_s;
        end
        coal_hit = |coal_vec_s;
    end

    // Forwarding priority: a non-head entry is newer than the head entry.
    always_comb begin
        fwd_hit        = 1'b0;
        fwd_data       = {DATA_W{1'b0}};
        fwd_head_hit_s = valid_r[head_idx] && (addr_r[head_idx] == fwd_addr);
        if (|fwd_vec_s) begin
            fwd_hit  = 1'b1;
            fwd_data = fwd_nh_data_s;
        end else if (fwd_head_hit_s) begin
            fwd_hit  = 1'b1;
            fwd_data = data_r[head_idx];
        end else begin
            fwd_hit  = 1'b0;
            fwd_data = {DATA_W{1'b0}};
        end
    end

    // Plain read port for loading the RAM request registers.
    always_comb begin
        rd_addr = addr_r[rd_idx];
        rd_data = data_r[rd_idx];
    end

    // Slot storage: a pop clears the head valid, a write (new or coalesce)
    // sets its slot; the two never target the same slot in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= {ADDR_W{1'b0}};
                data_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (clr_en) begin
                valid_r[clr_idx] <= 1'b0;
            end
            if (wr_en) begin
                valid_r[wr_idx] <= 1'b1;
                addr_r[wr_idx]  <= wr_addr;
                data_r[wr_idx]  <= wr_data;
            end
        end
    end

endmodule : wb_entry_array

// File: rtl/mem_write_buffer.sv
// ----------------------------------------------------------------------------
// mem_write_buffer
// Write-through store buffer between the cache controller and main memory.
// Queues stores in a circular FIFO, coalesces repeat stores to a queued
// (non-head) address, drains to RAM over a valid/ack handshake and forwards
// the newest queued data to lookups.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   wr_req/wr_addr/wr_data/wr_ready store input from cache controller
//   rd_req/rd_addr -> rd_hit/rd_hit_data  registered forwarding lookup
//   mem_we/mem_addr/mem_wdata/mem_ack     RAM write handshake
//   empty                           nothing queued and nothing in flight
// ----------------------------------------------------------------------------
module mem_write_buffer
    import mem_write_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_hit,
    output logic [DATA_W-1:0] rd_hit_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    wb_state_e         state_r, state_nxt_s;
    logic [PTR_W-1:0]  head_r, tail_r;
    logic [CNT_W-1:0]  count_r;

    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              rd_hit_r;
    logic [DATA_W-1:0] rd_hit_data_r;

    logic              push_s, push_new_s, pop_s;
    logic              coal_hit_s;
    logic [PTR_W-1:0]  coal_idx_s;
    logic [PTR_W-1:0]  wr_idx_s;
    logic [PTR_W-1:0]  next_head_s;
    logic [CNT_W-1:0]  remain_s;
    logic              load_s;
    logic [PTR_W-1:0]  load_idx_s;
    logic              load_bypass_s;
    logic [ADDR_W-1:0] arr_rd_addr_s;
    logic [DATA_W-1:0] arr_rd_data_s;
    logic              arr_fwd_hit_s;
    logic [DATA_W-1:0] arr_fwd_data_s;
    logic              fwd_hit_s;
    logic [DATA_W-1:0] fwd_data_s;

    // Ready is decoded from the registered count only, so a pop in the same
    // cycle cannot open the buffer early.
    assign wr_ready    = (count_r != CNT_FULL);
    assign empty       = (count_r == CNT_ZERO) && (state_r == WB_IDLE);
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign rd_hit      = rd_hit_r;
    assign rd_hit_data = rd_hit_data_r;

    assign push_s      = wr_req && wr_ready;
    assign push_new_s  = push_s && !coal_hit_s;
    assign pop_s       = (state_r == WB_DRAIN) && mem_ack;
    assign wr_idx_s    = coal_hit_s ? coal_idx_s : tail_r;
    assign next_head_s = head_r + PTR_ONE;
    // Entries left after this cycle's pop, counting a same-cycle new push.
    assign remain_s    = count_r - CNT_ONE + {{(CNT_W-1){1'b0}}, push_new_s};
    // A slot being written this cycle must be loaded from the write port,
    // otherwise the RAM would see stale (pre-coalesce or empty) contents.
    assign load_bypass_s = push_s && (wr_idx_s == load_idx_s);

    wb_entry_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_entries (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (push_s),
        .wr_idx    (wr_idx_s),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_en    (pop_s),
        .clr_idx   (head_r),
        .head_idx  (head_r),
        .coal_addr (wr_addr),
        .coal_hit  (coal_hit_s),
        .coal_idx  (coal_idx_s),
        .fwd_addr  (rd_addr),
        .fwd_hit   (arr_fwd_hit_s),
        .fwd_data  (arr_fwd_data_s),
        .rd_idx    (load_idx_s),
        .rd_addr   (arr_rd_addr_s),
        .rd_data   (arr_rd_data_s)
    );

    // Drain FSM next-state and RAM-port load decision.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        load_idx_s  = head_r;
        case (state_r)
            WB_IDLE: begin
                if (count_r != CNT_ZERO) begin
                    state_nxt_s = WB_DRAIN;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = WB_IDLE;
                end
            end
            WB_DRAIN: begin
                if (mem_ack) begin
                    if (remain_s != CNT_ZERO) begin
                        state_nxt_s = WB_DRAIN;
                        load_s      = 1'b1;
                        load_idx_s  = next_head_s;
                    end else begin
                        state_nxt_s = WB_IDLE;
                    end
                end else begin
                    state_nxt_s = WB_DRAIN;
                end
            end
            default: begin
                state_nxt_s = WB_IDLE;
            end
        endcase
    end

    // Forwarding priority: same-cycle accepted store, then queued entries.
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = {DATA_W{1'b0}};
        if (push_s && (wr_addr == rd_addr)) begin
            fwd_hit_s  = 1'b1;
            fwd_data_s = wr_data;
        end else begin
            fwd_hit_s  = arr_fwd_hit_s;
            fwd_data_s = arr_fwd_data_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= WB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= CNT_ZERO;
        end else begin
            if (pop_s) begin
                head_r <= next_head_s;
            end
            if (push_new_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            case ({push_new_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // RAM request registers: held stable until ack, reloaded on advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else begin
            mem_we_r <= (state_nxt_s == WB_DRAIN);
            if (load_s) begin
                mem_addr_r  <= load_bypass_s ? wr_addr : arr_rd_addr_s;
                mem_wdata_r <= load_bypass_s ? wr_data : arr_rd_data_s;
            end
        end
    end

    // Registered forwarding result; data holds its last hit value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_hit_r      <= 1'b0;
            rd_hit_data_r <= {DATA_W{1'b0}};
        end else begin
            rd_hit_r <= rd_req && fwd_hit_s;
            if (rd_req && fwd_hit_s) begin
                rd_hit_data_r <= fwd_data_s;
            end
        end
    end

endmodule : mem_write_buffer

// File: tb/tb_mem_write_buffer.sv
// ----------------------------------------------------------------------------
// tb_mem_write_buffer
// Directed self-checking bench for mem_write_buffer. A monitor logs every
// accepted RAM write (mem_we & mem_ack at a rising edge); each scenario task
// compares DUT outputs and the log against hand-computed values.
// ----------------------------------------------------------------------------
module tb_mem_write_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_req = 1'b0;
    logic [15:0] wr_addr = 16'h0;
    logic [31:0] wr_data = 32'h0;
    logic        wr_ready;
    logic        rd_req = 1'b0;
    logic [15:0] rd_addr = 16'h0;
    logic        rd_hit;
    logic [31:0] rd_hit_data;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic        empty;

    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0] log_addr [$];
    logic [31:0] log_data [$];

    mem_write_buffer #(.DEPTH(4), .ADDR_W(16), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_hit_data(rd_hit_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .empty(empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && mem_we && mem_ack) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic wait_empty(input int max_cycles, input string tag);
        int k = 0;
        while (!empty && k < max_cycles) begin
            tick();
            k++;
        end
        n_cmp++;
        if (!empty) begin
            n_fail++;
            $display("FAIL %s_drain_timeout: empty=%0b after %0d cycles, required 1", tag, empty, max_cycles);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %0b want 1", wr_ready); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0b want 1", empty); end
        n_cmp++; if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL reset_rd_hit: got %0b want 0", rd_hit); end
        n_cmp++; if (mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_mem_bus: got %h/%h want 0000/00000000", mem_addr, mem_wdata);
        end
    endtask

    task automatic test_single_store();
        clear_log();
        mem_ack = 1'b1;
        wr_req = 1'b1; wr_addr = 16'h0004; wr_data = 32'h1111AAAA;
        tick();                                  // edge N: accepted
        wr_req = 1'b0;
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL single_we_after_N: got %0b want 0", mem_we); end
        tick();                                  // edge N+1
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 16'h0004 || mem_wdata !== 32'h1111AAAA) begin
            n_fail++; $display("FAIL single_we_after_N1: got we=%0b %h/%h want 1 0004/1111aaaa", mem_we, mem_addr, mem_wdata);
        end
        tick();                                  // edge N+2: acked
        n_cmp++; if (mem_we !== 1'b0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL single_done: got we=%0b empty=%0b want 0/1", mem_we, empty);
        end
        n_cmp++; if (log_addr.size() !== 1) begin
            n_fail++; $display("FAIL single_write_count: got %0d want 1", log_addr.size());
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_full_backpressure();
        logic [15:0] ea [5] = '{16'h0004, 16'h0404, 16'h0804, 16'h0C04, 16'h1004};
        logic [31:0] ed [5] = '{32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003, 32'hAAAA0004, 32'hAAAA0005};
        clear_log();
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_req = 1'b1; wr_addr = ea[i]; wr_data = ed[i];
            tick();
        end
        n_cmp++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_wr_ready: got %0b want 0", wr_ready); end
        wr_addr = ea[4]; wr_data = ed[4];        // 5th store held by upstream
        tick(); tick();
        n_cmp++; if (wr_ready !== 1'b0 || mem_addr !== 16'h0004 || mem_we !== 1'b1) begin
            n_fail++; $display("FAIL full_hold: got ready=%0b we=%0b addr=%h want 0/1/0004", wr_ready, mem_we, mem_addr);
        end
        mem_ack = 1'b1;
        tick();                                  // first pop; 5th not yet accepted
        n_cmp++; if (wr_ready !== 1'b1 || mem_addr !== 16'h0404) begin
            n_fail++; $display("FAIL full_after_pop: got ready=%0b addr=%h want 1/0404", wr_ready, mem_addr);
        end
        tick();                                  // 5th accepted here
        wr_req = 1'b0;
        wait_empty(20, "full");
        n_cmp++; if (log_addr.size() !== 5) begin n_fail++; $display("FAIL full_log_len: got %0d want 5", log_addr.size()); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (i >= log_addr.size() || log_addr[i] !== ea[i] || log_data[i] !== ed[i]) begin
                n_fail++;
                $display("FAIL full_log_%0d: got %h/%h want %h/%h", i,
                         (i < log_addr.size()) ? log_addr[i] : 16'hxxxx,
                         (i < log_data.size()) ? log_data[i] : 32'hxxxxxxxx, ea[i], ed[i]);
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_coalesce();
        clear_log();
        mem_ack = 1'b0;
        wr_req = 1'b1; wr_addr = 16'h0404; wr_data = 32'hAAAA000A; tick();
        wr_addr = 16'h0804; wr_data = 32'hAAAA000B; tick();
        wr_addr = 16'h0804; wr_data = 32'hAAAA000C; tick();
        wr_req = 1'b0;
        n_cmp++; if (dut.count_r !== 3'd2) begin n_fail++; $display("FAIL coal_count: got %0d want 2", dut.count_r); end
        mem_ack = 1'b1;
        wait_empty(10, "coal");
        n_cmp++; if (log_addr.size() !== 2) begin n_fail++; $display("FAIL coal_log_len: got %0d want 2", log_addr.size()); end
        n_cmp++; if (log_addr.size() < 2 || log_addr[0] !== 16'h0404 || log_data[0] !== 32'hAAAA000A) begin
            n_fail++; $display("FAIL coal_first: log[0] wrong, want 0404/aaaa000a");
        end
        n_cmp++; if (log_addr.size() < 2 || log_addr[1] !== 16'h0804 || log_data[1] !== 32'hAAAA000C) begin
            n_fail++; $display("FAIL coal_second: log[1] wrong, want 0804/aaaa000c");
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_forwarding();
        clear_log();
        mem_ack = 1'b0;
        wr_req = 1'b1; wr_addr = 16'h0C04; wr_data = 32'hAAAA0004; tick();
        wr_req = 1'b0; tick();                   // head now in flight
        rd_req = 1'b1; rd_addr = 16'h0C04; tick();
        n_cmp++; if (rd_hit !== 1'b1 || rd_hit_data !== 32'hAAAA0004) begin
            n_fail++; $display("FAIL fwd_head: got %0b/%h want 1/aaaa0004", rd_hit, rd_hit_data);
        end
        rd_addr = 16'hFFFF; tick();
        n_cmp++; if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_miss: got %0b want 0", rd_hit); end
        wr_req = 1'b1; wr_addr = 16'hFFFF; wr_data = 32'hDEADBEEF; tick();
        n_cmp++; if (rd_hit !== 1'b1 || rd_hit_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL fwd_same_cycle: got %0b/%h want 1/deadbeef", rd_hit, rd_hit_data);
        end
        rd_req = 1'b0;
        wr_addr = 16'h0C04; wr_data = 32'hBBBB0004; tick();
        wr_req = 1'b0;
        n_cmp++; if (rd_hit !== 1'b0 || rd_hit_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL fwd_idle_hold: got %0b/%h want 0/deadbeef", rd_hit, rd_hit_data);
        end
        rd_req = 1'b1; rd_addr = 16'h0C04; tick();
        rd_req = 1'b0;
        n_cmp++; if (rd_hit !== 1'b1 || rd_hit_data !== 32'hBBBB0004) begin
            n_fail++; $display("FAIL fwd_newest: got %0b/%h want 1/bbbb0004", rd_hit, rd_hit_data);
        end
        mem_ack = 1'b1;
        wait_empty(10, "fwd");
        n_cmp++; if (log_addr.size() !== 3 || log_data[0] !== 32'hAAAA0004 ||
                     log_data[1] !== 32'hDEADBEEF || log_data[2] !== 32'hBBBB0004) begin
            n_fail++; $display("FAIL fwd_drain_order: got %0d writes, want aaaa0004,deadbeef,bbbb0004", log_addr.size());
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        clear_log();
        mem_ack = 1'b0;
        wr_req = 1'b1; wr_addr = 16'h1234; wr_data = 32'hCAFEF00D; tick();
        wr_req = 1'b0; tick();
        n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rst_pre_we: got %0b want 1", mem_we); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_we !== 1'b0 || empty !== 1'b1 || wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_async: got we=%0b empty=%0b ready=%0b want 0/1/1", mem_we, empty, wr_ready);
        end
        tick();
        rst_n = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++; if (mem_we !== 1'b0 || log_addr.size() !== 0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL rst_no_stale: got we=%0b writes=%0d empty=%0b want 0/0/1", mem_we, log_addr.size(), empty);
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_full_backpressure();
        test_coalesce();
        test_forwarding();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_mem_write_buffer
